hrm_ctrl: RTL and testbench

//  Control unit sequencing the HRM CPU datapath: fetch, decode, operand/indirect resolution, execute.

---
 rtl/hrm_ctrl_pkg.sv | 55 +++++
 rtl/hrm_ctrl_decode.sv | 24 ++
 rtl/hrm_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hrm_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hrm_ctrl_pkg.sv
// Shared constants for the HRM control unit: opcodes, FSM state codes,
// datapath select codes and the decoded-instruction record.
package hrm_ctrl_pkg;

    localparam int OPW_DEF = 4;
    localparam int DW_DEF  = 8;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPUP   = 4'h6;
    localparam logic [3:0] OP_BUMPDN   = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_FETCH_OP = 4'd2;
    localparam logic [3:0] ST_ADDR     = 4'd3;
    localparam logic [3:0] ST_INDIR    = 4'd4;
    localparam logic [3:0] ST_EXEC     = 4'd5;
    localparam logic [3:0] ST_STORE    = 4'd6;
    localparam logic [3:0] ST_BRANCH   = 4'd7;
    localparam logic [3:0] ST_WAIT_IN  = 4'd8;
    localparam logic [3:0] ST_WAIT_OUT = 4'd9;
    localparam logic [3:0] ST_HALT     = 4'd10;

    localparam logic [1:0] MUXR_INBOX = 2'd0;
    localparam logic [1:0] MUXR_MEM   = 2'd1;
    localparam logic [1:0] MUXR_ALU   = 2'd2;

    localparam logic MUXAR_OPND = 1'b0;
    localparam logic MUXAR_MEM  = 1'b1;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_INC  = 2'd2;
    localparam logic [1:0] ALU_DEC  = 2'd3;

    typedef struct packed {
        logic needs_op;
        logic is_jump;
        logic is_mem;
        logic is_alu;
        logic is_bump;
        logic indirect;
        logic illegal;
    } decode_t;

endpackage

// File: rtl/hrm_ctrl_decode.sv
// Combinational classification of the latched instruction byte.
module hrm_ctrl_decode
    import hrm_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    input  logic           ind_bit,
    output decode_t        dec
);

    always_comb begin
        dec          = '0;
        dec.is_mem   = (opcode >= OP_COPYFROM) && (opcode <= OP_BUMPDN);
        dec.is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB);
        dec.is_bump  = (opcode == OP_BUMPUP) || (opcode == OP_BUMPDN);
        dec.is_jump  = (opcode >= OP_JUMP) && (opcode <= OP_JUMPN);
        dec.needs_op = dec.is_mem || dec.is_jump;
        // The indirect bit only means something for memory-addressing ops.
        dec.indirect = ind_bit && dec.is_mem;
        dec.illegal  = (opcode > OP_JUMPN) && (opcode != OP_HALT);
    end

endmodule

// File: rtl/hrm_ctrl.sv
// HRM CPU control FSM: fetch, decode, operand/indirect resolution, execute,
// plus INBOX/OUTBOX handshakes. Strobe outputs are combinational from state.
module hrm_ctrl
    import hrm_ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int DW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] instr,
    input  logic          r_zero,
    input  logic          r_neg,
    input  logic          inbox_empty,
    input  logic          outbox_full,
    output logic          wIR,
    output logic          wOP,
    output logic          wAR,
    output logic          muxAR,
    output logic          wPC,
    output logic          branch,
    output logic          ijump,
    output logic          aluFlag,
    output logic          wR,
    output logic [1:0]    muxR,
    output logic [1:0]    aluCtl,
    output logic          wM,
    output logic          inbox_rd,
    output logic          outbox_wr,
    output logic          halted,
    output logic          illegal
);

    logic [3:0]     state_reg, state_next;
    logic [OPW-1:0] opcode_reg;
    logic           ind_reg;
    logic           illegal_reg;
    decode_t        dec;

    logic wir_c, wop_c, war_c, muxar_c, wpc_c, branch_c, ijump_c, aluflag_c;
    logic wr_c, wm_c, inbox_rd_c, outbox_wr_c;
    logic [1:0] muxr_c, aluctl_c;

    logic unused_bits;
    assign unused_bits = ^instr[DW-OPW-2:0];

    hrm_ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode  (opcode_reg),
        .ind_bit (ind_reg),
        .dec     (dec)
    );

    // The controller keeps its own copy of the opcode: once PC advances,
    // instr shows the operand byte, not the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            opcode_reg  <= '0;
            ind_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH) begin
                opcode_reg <= instr[DW-1:DW-OPW];
                ind_reg    <= instr[DW-OPW-1];
            end
            if (state_reg == ST_DECODE && dec.illegal) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        wir_c       = 1'b0;
        wop_c       = 1'b0;
        war_c       = 1'b0;
        muxar_c     = MUXAR_OPND;
        wpc_c       = 1'b0;
        branch_c    = 1'b0;
        ijump_c     = 1'b0;
        aluflag_c   = 1'b0;
        wr_c        = 1'b0;
        muxr_c      = MUXR_INBOX;
        aluctl_c    = ALU_ADD;
        wm_c        = 1'b0;
        inbox_rd_c  = 1'b0;
        outbox_wr_c = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                wir_c      = 1'b1;
                wpc_c      = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode_reg)
                    OP_INBOX:  state_next = ST_WAIT_IN;
                    OP_OUTBOX: state_next = ST_WAIT_OUT;
                    OP_HALT:   state_next = ST_HALT;
                    default:   state_next = dec.illegal ? ST_HALT : ST_FETCH_OP;
                endcase
            end
            ST_FETCH_OP: begin
                wop_c = dec.needs_op;
                // Jumps leave PC on the operand byte so a not-taken branch
                // can step over it with a plain increment.
                wpc_c      = dec.is_mem;
                state_next = dec.is_jump ? ST_BRANCH : ST_ADDR;
            end
            ST_ADDR: begin
                war_c      = 1'b1;
                muxar_c    = MUXAR_OPND;
                state_next = dec.indirect ? ST_INDIR : ST_EXEC;
            end
            ST_INDIR: begin
                war_c      = 1'b1;
                muxar_c    = MUXAR_MEM;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (opcode_reg)
                    OP_COPYFROM: begin
                        wr_c   = 1'b1;
                        muxr_c = MUXR_MEM;
                    end
                    OP_COPYTO: wm_c = 1'b1;
                    OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: begin
                        wr_c     = 1'b1;
                        muxr_c   = MUXR_ALU;
                        aluctl_c = opcode_reg[1:0];
                        if (dec.is_bump) state_next = ST_STORE;
                    end
                    default: ;
                endcase
            end
            ST_STORE: begin
                wm_c       = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                wpc_c    = 1'b1;
                branch_c = 1'b1;
                ijump_c  = (opcode_reg == OP_JUMP);
                if (opcode_reg == OP_JUMPZ) aluflag_c = r_zero;
                if (opcode_reg == OP_JUMPN) aluflag_c = r_neg;
                state_next = ST_FETCH;
            end
            ST_WAIT_IN: begin
                if (!inbox_empty) begin
                    inbox_rd_c = 1'b1;
                    wr_c       = 1'b1;
                    muxr_c     = MUXR_INBOX;
                    state_next = ST_FETCH;
                end
            end
            ST_WAIT_OUT: begin
                if (!outbox_full) begin
                    outbox_wr_c = 1'b1;
                    state_next  = ST_FETCH;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    // Reset suppresses every strobe so an aborted instruction has no side effect.
    assign wIR       = wir_c       && !rst;
    assign wOP       = wop_c       && !rst;
    assign wAR       = war_c       && !rst;
    assign muxAR     = muxar_c     && !rst;
    assign wPC       = wpc_c       && !rst;
    assign branch    = branch_c    && !rst;
    assign ijump     = ijump_c     && !rst;
    assign aluFlag   = aluflag_c   && !rst;
    assign wR        = wr_c        && !rst;
    assign muxR      = rst ? 2'd0 : muxr_c;
    assign aluCtl    = rst ? 2'd0 : aluctl_c;
    assign wM        = wm_c        && !rst;
    assign inbox_rd  = inbox_rd_c  && !rst;
    assign outbox_wr = outbox_wr_c && !rst;
    assign halted    = (state_reg == ST_HALT);
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_hrm_ctrl.sv
// Directed, table-driven check of the HRM control FSM, one vector per clock.
module tb_hrm_ctrl;

    typedef struct packed {
        logic       wir, wop, war, muxar, wpc, branch, ijump, aluflag, wr;
        logic [1:0] muxr, aluctl;
        logic       wm, inbox_rd, outbox_wr, halted, illegal;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] instr;
        logic       r_zero, r_neg, inbox_empty, outbox_full;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       r_zero = 1'b0, r_neg = 1'b0, inbox_empty = 1'b0, outbox_full = 1'b0;
    logic       wIR, wOP, wAR, muxAR, wPC, branch, ijump, aluFlag, wR, wM;
    logic       inbox_rd, outbox_wr, halted, illegal;
    logic [1:0] muxR, aluCtl;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hrm_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .r_zero(r_zero), .r_neg(r_neg),
        .inbox_empty(inbox_empty), .outbox_full(outbox_full),
        .wIR(wIR), .wOP(wOP), .wAR(wAR), .muxAR(muxAR), .wPC(wPC),
        .branch(branch), .ijump(ijump), .aluFlag(aluFlag), .wR(wR),
        .muxR(muxR), .aluCtl(aluCtl), .wM(wM), .inbox_rd(inbox_rd),
        .outbox_wr(outbox_wr), .halted(halted), .illegal(illegal)
    );

    function automatic outs_t o_none();
        return '0;
    endfunction
    function automatic outs_t o_fetch();
        outs_t o = '0; o.wir = 1'b1; o.wpc = 1'b1; return o;
    endfunction
    function automatic outs_t o_fop(logic pc);
        outs_t o = '0; o.wop = 1'b1; o.wpc = pc; return o;
    endfunction
    function automatic outs_t o_addr(logic ind);
        outs_t o = '0; o.war = 1'b1; o.muxar = ind; return o;
    endfunction
    function automatic outs_t o_br(logic ij, logic af);
        outs_t o = '0; o.wpc = 1'b1; o.branch = 1'b1; o.ijump = ij; o.aluflag = af; return o;
    endfunction
    function automatic outs_t o_in();
        outs_t o = '0; o.inbox_rd = 1'b1; o.wr = 1'b1; o.muxr = 2'd0; return o;
    endfunction
    function automatic outs_t o_out();
        outs_t o = '0; o.outbox_wr = 1'b1; return o;
    endfunction
    function automatic outs_t o_exec(logic [1:0] mr, logic [1:0] ac);
        outs_t o = '0; o.wr = 1'b1; o.muxr = mr; o.aluctl = ac; return o;
    endfunction
    function automatic outs_t o_wm();
        outs_t o = '0; o.wm = 1'b1; return o;
    endfunction
    function automatic outs_t o_halt(logic il);
        outs_t o = '0; o.halted = 1'b1; o.illegal = il; return o;
    endfunction

    function automatic vec_t v(string name, logic [7:0] ins, outs_t exp,
                               logic rz = 1'b0, logic rn = 1'b0, logic ie = 1'b0,
                               logic of = 1'b0, logic r = 1'b0);
        vec_t t;
        t.name = name; t.rst = r; t.instr = ins; t.r_zero = rz; t.r_neg = rn;
        t.inbox_empty = ie; t.outbox_full = of; t.exp = exp;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        outs_t got;
        @(negedge clk);
        rst = t.rst; instr = t.instr; r_zero = t.r_zero; r_neg = t.r_neg;
        inbox_empty = t.inbox_empty; outbox_full = t.outbox_full;
        #1;
        got = {wIR, wOP, wAR, muxAR, wPC, branch, ijump, aluFlag, wR,
               muxR, aluCtl, wM, inbox_rd, outbox_wr, halted, illegal};
        total++;
        if (got !== t.exp) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h", t.name, got, t.exp);
        end else begin
            $display("vec %-12s instr=%02h outs=%05h ok", t.name, t.instr, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset held with an INBOX byte present: FETCH strobes must stay low.
        vecs.push_back(v("rst_hold",  8'h00, o_none(), 0, 0, 0, 0, 1));
        vecs.push_back(v("in_fetch",  8'h00, o_fetch()));
        vecs.push_back(v("in_dec",    8'h00, o_none()));
        vecs.push_back(v("in_take",   8'h00, o_in()));
        vecs.push_back(v("out_fetch", 8'h10, o_fetch()));
        vecs.push_back(v("out_dec",   8'h00, o_none()));
        vecs.push_back(v("out_full",  8'h00, o_none(), 0, 0, 0, 1));
        vecs.push_back(v("out_go",    8'h00, o_out()));
        vecs.push_back(v("jmp_fetch", 8'h80, o_fetch()));
        vecs.push_back(v("jmp_dec",   8'hB2, o_none()));
        vecs.push_back(v("jmp_fop",   8'hB2, o_fop(0)));
        vecs.push_back(v("jmp_br",    8'hB2, o_br(1, 0)));
        vecs.push_back(v("jzt_fetch", 8'h90, o_fetch()));
        vecs.push_back(v("jzt_dec",   8'hA0, o_none()));
        vecs.push_back(v("jzt_fop",   8'hA0, o_fop(0)));
        vecs.push_back(v("jzt_br",    8'hA0, o_br(0, 1), 1, 0));
        vecs.push_back(v("jzn_fetch", 8'h90, o_fetch()));
        vecs.push_back(v("jzn_dec",   8'hA0, o_none()));
        vecs.push_back(v("jzn_fop",   8'hA0, o_fop(0)));
        vecs.push_back(v("jzn_br",    8'hA0, o_br(0, 0), 0, 1));
        vecs.push_back(v("jn_fetch",  8'hA0, o_fetch()));
        vecs.push_back(v("jn_dec",    8'h10, o_none()));
        vecs.push_back(v("jn_fop",    8'h10, o_fop(0)));
        vecs.push_back(v("jn_br",     8'h10, o_br(0, 1), 0, 1));
        vecs.push_back(v("addi_fetch", 8'h48, o_fetch()));
        vecs.push_back(v("addi_dec",  8'h05, o_none()));
        vecs.push_back(v("addi_fop",  8'h05, o_fop(1)));
        vecs.push_back(v("addi_addr", 8'h05, o_addr(0)));
        vecs.push_back(v("addi_ind",  8'h05, o_addr(1)));
        vecs.push_back(v("addi_exec", 8'h05, o_exec(2, 0)));
        vecs.push_back(v("bdn_fetch", 8'h70, o_fetch()));
        vecs.push_back(v("bdn_dec",   8'h03, o_none()));
        vecs.push_back(v("bdn_fop",   8'h03, o_fop(1)));
        vecs.push_back(v("bdn_addr",  8'h03, o_addr(0)));
        vecs.push_back(v("bdn_exec",  8'h03, o_exec(2, 3)));
        vecs.push_back(v("bdn_store", 8'h03, o_wm()));
        vecs.push_back(v("cto_fetch", 8'h30, o_fetch()));
        vecs.push_back(v("cto_dec",   8'h07, o_none()));
        vecs.push_back(v("cto_fop",   8'h07, o_fop(1)));
        vecs.push_back(v("cto_addr",  8'h07, o_addr(0)));
        vecs.push_back(v("cto_exec",  8'h07, o_wm()));
        vecs.push_back(v("cfr_fetch", 8'h20, o_fetch()));
        vecs.push_back(v("cfr_dec",   8'h01, o_none()));
        vecs.push_back(v("cfr_fop",   8'h01, o_fop(1)));
        vecs.push_back(v("cfr_addr",  8'h01, o_addr(0)));
        vecs.push_back(v("cfr_exec",  8'h01, o_exec(1, 0)));
        vecs.push_back(v("subi_fetch", 8'h58, o_fetch()));
        vecs.push_back(v("subi_dec",  8'h02, o_none()));
        vecs.push_back(v("subi_fop",  8'h02, o_fop(1)));
        vecs.push_back(v("subi_addr", 8'h02, o_addr(0)));
        vecs.push_back(v("subi_ind",  8'h02, o_addr(1)));
        vecs.push_back(v("subi_exec", 8'h02, o_exec(2, 1)));
        vecs.push_back(v("jmpi_fetch", 8'h88, o_fetch()));
        vecs.push_back(v("jmpi_dec",  8'h00, o_none()));
        vecs.push_back(v("jmpi_fop",  8'h00, o_fop(0)));
        vecs.push_back(v("jmpi_br",   8'h00, o_br(1, 0), 1, 1));
        vecs.push_back(v("bupi_fetch", 8'h68, o_fetch()));
        vecs.push_back(v("bupi_dec",  8'h04, o_none()));
        vecs.push_back(v("bupi_fop",  8'h04, o_fop(1)));
        vecs.push_back(v("bupi_addr", 8'h04, o_addr(0)));
        vecs.push_back(v("bupi_ind",  8'h04, o_addr(1)));
        vecs.push_back(v("bupi_exec", 8'h04, o_exec(2, 2)));
        vecs.push_back(v("bupi_store", 8'h04, o_wm()));
        vecs.push_back(v("hlt_fetch", 8'hF0, o_fetch()));
        vecs.push_back(v("hlt_dec",   8'h00, o_none()));
        vecs.push_back(v("hlt_hold0", 8'h00, o_halt(0)));
        vecs.push_back(v("hlt_hold1", 8'h00, o_halt(0)));

        foreach (vecs[i]) apply(vecs[i]);

        // INBOX stall: nothing fires while empty, then one pop and back to FETCH.
        do_reset();
        apply(v("stl_fetch", 8'h00, o_fetch(), 0, 0, 1));
        apply(v("stl_dec",   8'h00, o_none(), 0, 0, 1));
        for (int i = 0; i < 5; i++) apply(v("stl_wait", 8'h00, o_none(), 0, 0, 1));
        apply(v("stl_take",  8'h00, o_in()));
        apply(v("stl_next",  8'h00, o_fetch()));

        // Undefined opcode: halt with illegal set, inputs ignored.
        do_reset();
        apply(v("ill_fetch", 8'hC0, o_fetch()));
        apply(v("ill_dec",   8'h00, o_none()));
        for (int i = 0; i < 10; i++) apply(v("ill_hold", 8'h00, o_halt(1), 1, 1, 0, 0));
        do_reset();
        apply(v("ill_rst",   8'h10, o_fetch()));

        // Reset in the middle of an ADD suppresses its ADDR strobe.
        do_reset();
        apply(v("ab_fetch",  8'h40, o_fetch()));
        apply(v("ab_dec",    8'h05, o_none()));
        apply(v("ab_fop",    8'h05, o_fop(1)));
        apply(v("ab_rst",    8'h05, o_none(), 0, 0, 0, 0, 1));
        apply(v("ab_refetch", 8'h00, o_fetch()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
